multicycle_control: RTL and testbench

- Main control FSM of the multicycle processor.
- Sequences one shared ALU, the instruction register, the register file and the unified memory port over several cycles per instruction.
- Drives the ALU's two-level operation select (alu_opp group select, alu_op function select) and all datapath mux/write enables.
- Supports memory wait states and a multi-cycle multiply.

---
 rtl/multicycle_control.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Main control FSM of the multicycle processor; sequences the
//            shared ALU, IR, register file and unified memory port.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zeroflag,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_opp,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_retired,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

    state_t             state_q,   state_d;
    logic [3:0]         mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               illegal_q, illegal_d;
    logic               retire;

    // zeroflag only qualifies pc_write_cond inside the datapath.
    logic unused_inputs;
    assign unused_inputs = ^{funct[5:2], zeroflag};

    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        illegal_d = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADDR: begin
                state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECUTE: begin
                // Multiply dwells MUL_LAT cycles; the counter is back at zero on exit.
                if ((funct[1:0] == 2'b10) && (mul_cnt_q != MUL_LAST)) begin
                    mul_cnt_d = mul_cnt_q + 4'd1;
                end else begin
                    mul_cnt_d = 4'd0;
                    state_d   = S_RWB;
                end
            end
            S_RWB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        retired_d = retire ? (retired_q + {{(CNT_W-1){1'b0}}, 1'b1}) : retired_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            mul_cnt_q <= 4'd0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_opp       = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_opp   = 2'b10;
                alu_op    = funct[1:0];
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                alu_opp   = 2'b10;
                alu_op    = funct[1:0];
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_opp       = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: ;
        endcase
        // Reset overrides the FETCH decode so nothing toggles while held.
        if (!rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_opp       = 2'b00;
            alu_op        = 2'b00;
            pc_source     = 2'b00;
        end
    end

    assign illegal_op    = illegal_q;
    assign instr_retired = retired_q;
    assign state_dbg     = rst ? state_q : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Vector table plus scoreboard bench for multicycle_control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    localparam int CW = 4;

    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4;
    localparam logic [3:0] MW = 4'd5, EX = 4'd6, RW = 4'd7, BR = 4'd8, JP = 4'd9;
    localparam logic [5:0] OPR = 6'h00, OLW = 6'h23, OSW = 6'h2B, OBQ = 6'h04;
    localparam logic [5:0] OJ = 6'h02, OBAD = 6'h3F;

    typedef struct packed {
        logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
        logic mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_opp, alu_op, pc_source;
    } ctrl_t;

    typedef struct {
        logic rst_n; logic [5:0] op; logic [5:0] fn; logic zf; logic mr;
        logic [3:0] st; logic ill; logic [CW-1:0] cnt;
    } vec_t;

    typedef struct {
        logic [3:0] st; ctrl_t ctrl; logic ill; logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0, rst = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic zeroflag = 1'b0, mem_ready = 1'b0;
    logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_opp, alu_op, pc_source;
    logic [CW-1:0] instr_retired;
    logic [3:0] state_dbg;

    int total = 0, bad = 0;
    vec_t vecs[$];
    exp_t sb[$];
    ctrl_t act_ctrl;

    always #5 clk = ~clk;

    multicycle_control #(.MUL_LAT(3), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .zeroflag(zeroflag), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_opp(alu_opp),
        .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
        .instr_retired(instr_retired), .state_dbg(state_dbg)
    );

    assign act_ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a,
                       alu_src_b, alu_opp, alu_op, pc_source};

    // Expected control word for a state, straight from the state table.
    function automatic ctrl_t model(input logic rst_n, input logic [3:0] st,
                                    input logic mr, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        if (!rst_n) return c;
        case (st)
            F:   begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            D:   c.alu_src_b = 2'b11;
            MA:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            MR:  begin c.mem_read = 1; c.iord = 1; end
            MWB: begin c.reg_write = 1; c.mem_to_reg = 1; end
            MW:  begin c.mem_write = 1; c.iord = 1; end
            EX:  begin c.alu_src_a = 1; c.alu_opp = 2'b10; c.alu_op = fn[1:0]; end
            RW:  begin c.reg_write = 1; c.reg_dst = 1; c.alu_opp = 2'b10; c.alu_op = fn[1:0]; end
            BR:  begin c.alu_src_a = 1; c.alu_opp = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            JP:  begin c.pc_write = 1; c.pc_source = 2'b10; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic v(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic zf, input logic mr, input logic [3:0] st,
                     input logic ill, input int cnt);
        vec_t e;
        e.rst_n = r; e.op = op; e.fn = fn; e.zf = zf; e.mr = mr;
        e.st = st; e.ill = ill; e.cnt = CW'(cnt);
        vecs.push_back(e);
    endtask

    task automatic apply(input vec_t e);
        exp_t x;
        @(posedge clk);
        #1;
        rst = e.rst_n; opcode = e.op; funct = e.fn; zeroflag = e.zf; mem_ready = e.mr;
        x.st = e.st; x.ctrl = model(e.rst_n, e.st, e.mr, e.fn); x.ill = e.ill; x.cnt = e.cnt;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            total += 4;
            if (state_dbg !== x.st) begin
                bad++; $display("FAIL state t=%0t got=%0d want=%0d", $time, state_dbg, x.st);
            end
            if (act_ctrl !== x.ctrl) begin
                bad++; $display("FAIL ctrl t=%0t st=%0d got=%05h want=%05h", $time, x.st, act_ctrl, x.ctrl);
            end
            if (illegal_op !== x.ill) begin
                bad++; $display("FAIL illegal_op t=%0t got=%0b want=%0b", $time, illegal_op, x.ill);
            end
            if (instr_retired !== x.cnt) begin
                bad++; $display("FAIL retired t=%0t got=%0d want=%0d", $time, instr_retired, x.cnt);
            end
            total++;
            if (mem_read === 1'b1 && mem_write === 1'b1) begin
                bad++; $display("FAIL mem_rw_excl t=%0t got=11 want=not both", $time);
            end
        end
    end

    initial begin
        // Reset, then lw interrupted by reset in MEMREAD
        v(0, OLW, 6'h00, 0, 0, F, 0, 0);
        v(0, OLW, 6'h00, 0, 0, F, 0, 0);
        v(1, OLW, 6'h00, 0, 1, F, 0, 0);
        v(1, OLW, 6'h00, 0, 1, D, 0, 0);
        v(1, OLW, 6'h00, 0, 1, MA, 0, 0);
        v(1, OLW, 6'h00, 0, 0, MR, 0, 0);
        v(0, OLW, 6'h00, 0, 0, F, 0, 0);
        // R-type add
        v(1, OPR, 6'h20, 0, 0, F, 0, 0);
        v(1, OPR, 6'h20, 0, 1, F, 0, 0);
        v(1, OPR, 6'h20, 0, 1, D, 0, 0);
        v(1, OPR, 6'h20, 0, 1, EX, 0, 0);
        v(1, OPR, 6'h20, 0, 1, RW, 0, 0);
        // multiply, funct[1:0]=10
        v(1, OPR, 6'h1A, 0, 1, F, 0, 1);
        v(1, OPR, 6'h1A, 0, 1, D, 0, 1);
        v(1, OPR, 6'h1A, 0, 1, EX, 0, 1);
        v(1, OPR, 6'h1A, 0, 1, EX, 0, 1);
        v(1, OPR, 6'h1A, 0, 1, EX, 0, 1);
        v(1, OPR, 6'h1A, 0, 1, RW, 0, 1);
        // lw with wait states
        v(1, OLW, 6'h00, 0, 0, F, 0, 2);
        v(1, OLW, 6'h00, 0, 0, F, 0, 2);
        v(1, OLW, 6'h00, 0, 1, F, 0, 2);
        v(1, OLW, 6'h00, 0, 1, D, 0, 2);
        v(1, OLW, 6'h00, 0, 1, MA, 0, 2);
        v(1, OLW, 6'h00, 0, 0, MR, 0, 2);
        v(1, OLW, 6'h00, 0, 0, MR, 0, 2);
        v(1, OLW, 6'h00, 0, 0, MR, 0, 2);
        v(1, OLW, 6'h00, 0, 1, MR, 0, 2);
        v(1, OLW, 6'h00, 0, 0, MWB, 0, 2);
        // sw
        v(1, OSW, 6'h00, 0, 1, F, 0, 3);
        v(1, OSW, 6'h00, 0, 1, D, 0, 3);
        v(1, OSW, 6'h00, 0, 1, MA, 0, 3);
        v(1, OSW, 6'h00, 0, 1, MW, 0, 3);
        // beq taken, then not taken
        v(1, OBQ, 6'h00, 1, 1, F, 0, 4);
        v(1, OBQ, 6'h00, 1, 1, D, 0, 4);
        v(1, OBQ, 6'h00, 1, 1, BR, 0, 4);
        v(1, OBQ, 6'h00, 0, 1, F, 0, 5);
        v(1, OBQ, 6'h00, 0, 1, D, 0, 5);
        v(1, OBQ, 6'h00, 0, 1, BR, 0, 5);
        // undecoded opcode
        v(1, OBAD, 6'h00, 0, 1, F, 0, 6);
        v(1, OBAD, 6'h00, 0, 1, D, 0, 6);
        v(1, OBAD, 6'h00, 0, 0, F, 1, 6);
        v(1, OBAD, 6'h00, 0, 0, F, 0, 6);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Ten jumps carry the 4-bit counter from 6 through 15 and wrap to 0
        for (int k = 0; k < 10; k++) begin
            vec_t e;
            int c;
            c = (6 + k) % 16;
            e.rst_n = 1; e.op = OJ; e.fn = 6'h00; e.zf = 0; e.ill = 0; e.cnt = CW'(c);
            e.mr = 1; e.st = F;  apply(e);
            e.mr = 0; e.st = D;  apply(e);
            e.mr = 1; e.st = JP; apply(e);
        end
        begin
            vec_t e;
            e.rst_n = 1; e.op = OJ; e.fn = 6'h00; e.zf = 0; e.mr = 0;
            e.st = F; e.ill = 0; e.cnt = '0;
            apply(e);
        end

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL drain got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
